// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path definitions: NRZI decoder state encoding and
// default line/stuffing constants used as parameter defaults.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2,
        ERR   = 2'd3
    } nrzi_state_t;

    localparam int unsigned USB_STUFF_LIMIT = 6;
    localparam logic        USB_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/nrzi_unstuff_decode_if.sv
// Sample-side and decoded-bit-side signals of the NRZI decoder.
// master: edge/timer logic plus receive shift register; slave: the decoder.
interface nrzi_unstuff_decode_if;

    logic d_plus;
    logic shift_enable;
    logic eop;
    logic d_orig;
    logic d_valid;
    logic stuff_err;

    modport master (
        output d_plus, shift_enable, eop,
        input  d_orig, d_valid, stuff_err
    );

    modport slave (
        input  d_plus, shift_enable, eop,
        output d_orig, d_valid, stuff_err
    );

endinterface

// File: rtl/nrzi_unstuff_decode.sv
// NRZI decoder with bit-unstuffing for the USB receive path.
// Emits one d_valid pulse per data bit; stuffed bits are dropped.
// Optional feature: define NRZI_STUFF_CHECK_EN to detect a missing stuff 0
// (ERR state, sticky stuff_err until EOP). Without it stuff_err is tied low.
module nrzi_unstuff_decode
    import usb_rx_pkg::*;
#(
    parameter int unsigned STUFF_LIMIT = USB_STUFF_LIMIT,
    parameter logic        IDLE_LEVEL  = USB_IDLE_LEVEL
) (
    input  logic                    clk,
    input  logic                    n_rst,
    nrzi_unstuff_decode_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(STUFF_LIMIT + 1);
    // Count value which, after one more decoded 1, forces a stuff bit.
    localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(STUFF_LIMIT - 1);

    nrzi_state_t      state;
    logic             prev_level;
    logic [CNT_W-1:0] ones_cnt;
    logic             d_orig_q;
    logic             d_valid_q;
    logic             dec_bit;

    // NRZI: no transition on the line means a 1.
    assign dec_bit = (bus.d_plus == prev_level);

`ifdef NRZI_STUFF_CHECK_EN
    logic stuff_err_q;
`endif

    // Decoder FSM; every register moves only on a shift_enable sample.
    // NOTE: state is updated with non-blocking assignments so every branch
    // reads the pre-edge values of state, ones_cnt and prev_level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            prev_level  <= IDLE_LEVEL;
            ones_cnt    <= '0;
            d_orig_q    <= 1'b1;
            d_valid_q   <= 1'b0;
`ifdef NRZI_STUFF_CHECK_EN
            stuff_err_q <= 1'b0;
`endif
        end else begin
            d_valid_q <= 1'b0;
            if (bus.shift_enable) begin
                if (bus.eop) begin
                    // EOP wins over everything: back to J idle, clean slate.
                    state       <= IDLE;
                    prev_level  <= IDLE_LEVEL;
                    ones_cnt    <= '0;
                    d_orig_q    <= 1'b1;
`ifdef NRZI_STUFF_CHECK_EN
                    stuff_err_q <= 1'b0;
`endif
                end else begin
                    prev_level <= bus.d_plus;
                    case (state)
                        IDLE, DATA: begin
                            d_orig_q  <= dec_bit;
                            d_valid_q <= 1'b1;
                            if (!dec_bit) begin
                                ones_cnt <= '0;
                                state    <= DATA;
                            end else if (ones_cnt == LAST_ONE) begin
                                ones_cnt <= '0;
                                state    <= STUFF;
                            end else begin
                                ones_cnt <= ones_cnt + CNT_W'(1);
                                state    <= DATA;
                            end
                        end
                        STUFF: begin
                            // Stuff sample is never emitted.
`ifdef NRZI_STUFF_CHECK_EN
                            if (dec_bit) begin
                                state       <= ERR;
                                stuff_err_q <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
`else
                            ones_cnt <= '0;
                            state    <= DATA;
`endif
                        end
`ifdef NRZI_STUFF_CHECK_EN
                        ERR: begin
                            // Packet is corrupt: swallow samples until EOP.
                            state <= ERR;
                        end
`endif
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.d_orig  = d_orig_q;
    assign bus.d_valid = d_valid_q;
`ifdef NRZI_STUFF_CHECK_EN
    assign bus.stuff_err = stuff_err_q;
`else
    assign bus.stuff_err = 1'b0;
`endif

endmodule
